// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, CRC-8 defaults and byte-wide CRC-8 update function
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic [7:0] CRC_POLY_DEF = 8'h07;
    localparam logic [7:0] CRC_INIT_DEF = 8'h00;

    // MSB-first, non-reflected CRC-8 over one byte
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data, input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/uart_crc8.sv
// uart_crc8: combinational byte-wide CRC-8 update, shared by transmitter and receiver checker
module uart_crc8 import uart_pkg::*; #(
    parameter logic [7:0] POLY = CRC_POLY_DEF
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_update(crc_in, data, POLY);

endmodule

// File: rtl/uart_crc_tx.sv
// uart_crc_tx: 8N1 UART transmitter that appends a CRC-8 character after the last payload byte
module uart_crc_tx import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 1042,
    parameter logic [7:0]  CRC_POLY     = CRC_POLY_DEF,
    parameter logic [7:0]  CRC_INIT     = CRC_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    tx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    crc;
    logic [7:0]    crc_next;
    logic          last_q;
    logic          crc_phase;
    logic          handshake;
    logic          bit_end;

    assign handshake = data_valid && data_ready;
    assign bit_end   = baud_cnt == CW'(CLKS_PER_BIT - 1);

    uart_crc8 #(.POLY(CRC_POLY)) u_crc8 (
        .crc_in  (crc),
        .data    (data_in),
        .crc_out (crc_next)
    );

    // Character framing FSM; the CRC character follows the last payload byte with no idle gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            crc        <= CRC_INIT;
            last_q     <= 1'b0;
            crc_phase  <= 1'b0;
            data_ready <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            baud_cnt   <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state      <= START;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        data_ready <= 1'b0;
                        shreg      <= data_in;
                        last_q     <= data_last;
                        crc        <= crc_next;
                    end else begin
                        data_ready <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (crc_phase) begin
                            state      <= IDLE;
                            tx_busy    <= 1'b0;
                            data_ready <= 1'b1;
                            frame_done <= 1'b1;
                            crc        <= CRC_INIT;
                            crc_phase  <= 1'b0;
                        end else if (last_q) begin
                            state     <= START;
                            tx        <= 1'b0;
                            crc_phase <= 1'b1;
                            shreg     <= crc;
                        end else begin
                            state      <= IDLE;
                            tx_busy    <= 1'b0;
                            data_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_crc_tx.sv
// tb_uart_crc_tx: randomized and directed frames checked against a bit-serial CRC model and a line decoder
module tb_uart_crc_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       tx_busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         run_q[$];
    longint     fd_q[$];
    int         run = 0;
    int         hs_n = 0;
    int         rdy_n = 0;
    longint     last_hs = 0;

    uart_crc_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as polynomial division of the message bit stream, one bit at a time
    function automatic logic [7:0] ref_crc(input logic [7:0] b[$]);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        foreach (b[i])
            for (int k = 7; k >= 0; k--) begin
                fb = r[7] ^ b[i][k];
                r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        return r;
    endfunction

    // Line decoder: samples each bit one cycle into its period
    always begin : mon
        logic [9:0] c;
        logic       ab;
        @(negedge clk);
        if (rst && !tx) begin
            ab = 1'b0;
            @(negedge clk);
            c[0] = tx;
            ab |= !rst;
            for (int k = 1; k < 10; k++) begin
                repeat (CPB) @(negedge clk);
                c[k] = tx;
                ab |= !rst;
            end
            if (!ab) begin
                check("start_bit", {31'd0, c[0]}, 0);
                check("stop_bit", {31'd0, c[9]}, 1);
                rx_q.push_back(c[8:1]);
            end
        end
    end

    always @(negedge clk) begin
        if (tx_busy) run++;
        else if (run != 0) begin
            run_q.push_back(run);
            run = 0;
        end
        if (frame_done) fd_q.push_back($time);
    end

    always @(posedge clk) begin
        if (rst && data_valid && data_ready) hs_n++;
        if (rst && data_ready) rdy_n++;
    end

    task automatic send_byte(input logic [7:0] b, input bit last, input bit hold);
        int n;
        n = 0;
        data_in = b;
        data_last = last;
        data_valid = 1'b1;
        while (!data_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, n < 400}, 1);
        @(posedge clk);
        last_hs = $time;
        @(negedge clk);
        if (!hold) begin
            n = 0;
            while (tx_busy && n < 400) begin
                data_valid = 1'($urandom);
                data_in = 8'($urandom);
                data_last = 1'($urandom);
                @(negedge clk);
                n++;
            end
            data_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] b[$], input bit hold, output logic [7:0] crc_seen);
        logic [7:0] exp_q[$];
        int rxb, rb, fb, hb, rdb, n;
        rxb = rx_q.size();
        rb = run_q.size();
        fb = fd_q.size();
        hb = hs_n;
        rdb = rdy_n;
        exp_q = b;
        exp_q.push_back(ref_crc(b));
        foreach (b[i]) begin
            send_byte(b[i], i == b.size() - 1, hold);
            if (i == 0) rdb = rdy_n;
        end
        data_valid = 1'b0;
        n = 0;
        while (!frame_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", {31'd0, frame_done}, 1);
        if (hold) check("ready_pulses", rdy_n - rdb, b.size() - 1);
        repeat (4) @(negedge clk);
        check("handshakes", hs_n - hb, b.size());
        check("frame_done_count", fd_q.size() - fb, 1);
        if (fd_q.size() > fb) check("frame_done_cycle", 32'((fd_q[fb] - last_hs - 5) / 10), 20 * CPB);
        check("char_count", rx_q.size() - rxb, exp_q.size());
        foreach (exp_q[i])
            if (rxb + i < rx_q.size()) check($sformatf("char%0d", i), {24'd0, rx_q[rxb + i]}, {24'd0, exp_q[i]});
        check("busy_runs", run_q.size() - rb, b.size());
        foreach (b[i])
            if (rb + i < run_q.size()) check($sformatf("busy_run%0d", i), run_q[rb + i], (i == b.size() - 1) ? 20 * CPB : 10 * CPB);
        crc_seen = (rx_q.size() - rxb == exp_q.size()) ? rx_q[rx_q.size() - 1] : 8'hxx;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] c;
        int fdb, len;
        #12;
        check("rst_tx", {31'd0, tx}, 1);
        check("rst_ready", {31'd0, data_ready}, 0);
        check("rst_busy", {31'd0, tx_busy}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, data_ready}, 1);

        q = {8'h01};
        run_frame(q, 1'b1, c);
        check("crc_01", {24'd0, c}, 32'h07);
        q = {8'hFF};
        run_frame(q, 1'b0, c);
        check("crc_ff", {24'd0, c}, 32'hF3);
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(q, 1'b1, c);
        check("crc_check_string", {24'd0, c}, 32'hF4);
        q = {8'h00};
        run_frame(q, 1'b1, c);
        check("crc_frame_a", {24'd0, c}, 32'h00);
        q = {8'h01};
        run_frame(q, 1'b1, c);
        check("crc_frame_b", {24'd0, c}, 32'h07);
        q = {8'hA5, 8'h3C};
        run_frame(q, 1'b0, c);

        data_in = 8'hF0;
        data_last = 1'b1;
        data_valid = 1'b1;
        while (!data_ready) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_abort_tx", {31'd0, tx}, 0);
        check("pre_abort_busy", {31'd0, tx_busy}, 1);
        fdb = fd_q.size();
        #2 rst = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx}, 1);
        check("abort_busy", {31'd0, tx_busy}, 0);
        check("abort_ready", {31'd0, data_ready}, 0);
        check("abort_frame_done", {31'd0, frame_done}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_abort", {31'd0, data_ready}, 1);
        repeat (50) @(negedge clk);
        check("no_frame_done_on_abort", fd_q.size() - fdb, 0);
        q = {8'h01};
        run_frame(q, 1'b0, c);
        check("crc_after_abort", {24'd0, c}, 32'h07);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 4);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_frame(q, 1'($urandom), c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
